// File: rtl/gcd_requester.sv
// Initiator for the 4-phase req/ack GCD operand protocol: takes an operand pair,
// sends A then B over the shared AB bus, and returns the captured result.
module gcd_requester #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_gcd,
    output logic             res_err,
    output logic             busy,
    output logic             gcd_req,
    output logic [WIDTH-1:0] gcd_ab,
    input  logic             gcd_ack,
    input  logic [WIDTH-1:0] gcd_c
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_REQ,
        S_A_REL,
        S_B_REQ,
        S_B_REL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Operand registers are pure data; the bus only shows them outside IDLE/DONE.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    logic   waiting;
    logic   ack_hit;
    state_t wait_next;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        waiting   = 1'b0;
        ack_hit   = 1'b0;
        wait_next = state_q;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    a_d   = op_a;
                    b_d   = op_b;
                    err_d = 1'b0;
                    if (op_a == '0 || op_b == '0) begin
                        res_d   = op_a | op_b;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_A_REQ;
                    end
                end
            end
            S_A_REQ: begin
                waiting   = 1'b1;
                ack_hit   = gcd_ack;
                wait_next = S_A_REL;
            end
            S_A_REL: begin
                waiting   = 1'b1;
                ack_hit   = !gcd_ack;
                wait_next = S_B_REQ;
            end
            S_B_REQ: begin
                waiting   = 1'b1;
                ack_hit   = gcd_ack;
                wait_next = S_B_REL;
                if (gcd_ack) begin
                    res_d = gcd_c;
                end
            end
            S_B_REL: begin
                waiting   = 1'b1;
                ack_hit   = !gcd_ack;
                wait_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An arriving ack wins over a timeout that expires on the same edge.
        if (waiting) begin
            if (ack_hit) begin
                state_d = wait_next;
            end else if (TO_EN && cnt_q == CNT_LAST) begin
                state_d = S_DONE;
                err_d   = 1'b1;
                res_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign res_gcd   = res_q;
    assign res_err   = err_q;
    assign gcd_req   = (state_q == S_A_REQ) || (state_q == S_B_REQ);

    always_comb begin
        gcd_ab = '0;
        case (state_q)
            S_A_REQ, S_A_REL: gcd_ab = a_q;
            S_B_REQ, S_B_REL: gcd_ab = b_q;
            default:          gcd_ab = '0;
        endcase
    end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: directed scenarios plus randomized pairs
// against a Euclid reference, with a behavioural 4-phase responder.
module tb_gcd_requester;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_gcd;
    logic         res_err;
    logic         busy;
    logic         gcd_req;
    logic [W-1:0] gcd_ab;
    logic         gcd_ack;
    logic [W-1:0] gcd_c;

    int checks = 0;
    int errors = 0;

    logic stuck   = 1'b0;
    int   rsp_dly = 0;
    int   req_cycles = 0;

    always #5 clk = ~clk;

    gcd_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_gcd  (res_gcd),
        .res_err  (res_err),
        .busy     (busy),
        .gcd_req  (gcd_req),
        .gcd_ab   (gcd_ab),
        .gcd_ack  (gcd_ack),
        .gcd_c    (gcd_c)
    );

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a, b, t;
        a = x;
        b = y;
        if (a == 0) return b;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [W-1:0] sub_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a, b;
        a = x;
        b = y;
        if (a == 0 || b == 0) return a | b;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Responder: acks A at once, acks B after rsp_dly extra cycles with the gcd on C.
    // C carries junk whenever it is not qualified by the B ack.
    logic         rsp_phase;
    int           rsp_cnt;
    logic [W-1:0] rsp_a;

    always @(posedge clk) begin
        if (!reset || stuck) begin
            gcd_ack   <= 1'b0;
            rsp_phase <= 1'b0;
            rsp_cnt   <= 0;
            gcd_c     <= W'($urandom);
        end else if (gcd_req && !gcd_ack) begin
            if (!rsp_phase) begin
                rsp_a   <= gcd_ab;
                gcd_ack <= 1'b1;
            end else if (rsp_cnt < rsp_dly) begin
                rsp_cnt <= rsp_cnt + 1;
            end else begin
                gcd_c   <= sub_gcd(rsp_a, gcd_ab);
                gcd_ack <= 1'b1;
            end
        end else if (!gcd_req && gcd_ack) begin
            gcd_ack   <= 1'b0;
            rsp_phase <= ~rsp_phase;
            rsp_cnt   <= 0;
            gcd_c     <= W'($urandom);
        end
    end

    // Protocol monitor
    initial begin : monitor
        logic         p_req;
        logic         p_ack;
        logic [W-1:0] p_ab;
        logic         p_rst;
        logic         ack_rose;
        p_req    = 1'b0;
        p_ack    = 1'b0;
        p_ab     = '0;
        p_rst    = 1'b0;
        ack_rose = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && p_rst === 1'b1) begin
                if (gcd_req && p_req)  check("ab_stable_while_req", 32'(gcd_ab), 32'(p_ab));
                if (gcd_req && !p_req) check("req_rise_needs_ack_low", 32'(p_ack), 0);
                if (ack_rose)          check("req_falls_cycle_after_ack", 32'(gcd_req), 0);
            end
            ack_rose = (reset === 1'b1) && gcd_ack && !p_ack;
            if (gcd_req === 1'b1) req_cycles++;
            p_req = gcd_req;
            p_ack = gcd_ack;
            p_ab  = gcd_ab;
            p_rst = reset;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_op_ready"},  32'(op_ready),  1);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_gcd_req"},   32'(gcd_req),   0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_res_gcd", 32'(res_gcd), 0);
        check("reset_res_err", 32'(res_err), 0);
        check("reset_gcd_ab",  32'(gcd_ab),  0);
        reset = 1'b1;
    endtask

    // One full transaction. exp_lat counts edges from the accept edge to DONE entry.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int dly,
                           input int hold, input logic [W-1:0] exp_gcd, input logic exp_err,
                           input int exp_lat, input string tag);
        int n;
        int r0;
        logic [W-1:0] held;
        @(negedge clk);
        rsp_dly  = dly;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        check({tag, "_op_ready_pre"}, 32'(op_ready), 1);
        r0 = req_cycles;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_res_valid"}, 32'(res_valid), 1);
        check({tag, "_latency"},   32'(n),         32'(exp_lat));
        check({tag, "_res_gcd"},   32'(res_gcd),   32'(exp_gcd));
        check({tag, "_res_err"},   32'(res_err),   32'(exp_err));
        check({tag, "_op_ready_done"}, 32'(op_ready), 0);
        check({tag, "_gcd_req_done"},  32'(gcd_req),  0);
        if (a == 0 || b == 0) check({tag, "_no_bus_req"}, 32'(req_cycles - r0), 0);
        held = res_gcd;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(res_valid), 1);
            check({tag, "_hold_gcd"},   32'(res_gcd),   32'(held));
            check({tag, "_hold_ready"}, 32'(op_ready),  0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_idle({tag, "_after"});
    endtask

    initial begin : stim
        logic [W-1:0] ra, rb;
        int d, h, n;
        reset     = 1'b0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        do_reset();

        run_txn(16'd12, 16'd18, 0, 0, 16'd6, 1'b0, 8, "t1_12_18");
        run_txn(16'd9,  16'd9,  2, 1, 16'd9, 1'b0, 10, "t2_9_9");
        run_txn(16'd0,  16'd7,  0, 0, 16'd7, 1'b0, 0, "t3_0_7");
        run_txn(16'd0,  16'd0,  0, 0, 16'd0, 1'b0, 0, "t3_0_0");
        run_txn(16'd5,  16'd0,  0, 0, 16'd5, 1'b0, 0, "t3_5_0");

        stuck = 1'b1;
        run_txn(16'd4, 16'd6, 0, 2, 16'd0, 1'b1, TO, "t4_timeout");
        stuck = 1'b0;
        do_reset();

        run_txn(16'd35, 16'd21, 1, 10, 16'd7, 1'b0, 9, "t5_35_21");

        // Reset while the B operand is on the bus
        @(negedge clk);
        rsp_dly  = 4;
        op_a     = 16'd100;
        op_b     = 16'd75;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (!(gcd_req === 1'b1 && gcd_ab === 16'd75) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_b_req", 32'(gcd_ab), 75);
        reset = 1'b0;
        @(negedge clk);
        check_idle("t6_midreset");
        reset = 1'b1;
        run_txn(16'd8, 16'd12, 0, 0, 16'd4, 1'b0, 8, "t6_8_12");

        for (int i = 0; i < 16; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 400));
            d  = $urandom_range(0, 4);
            h  = $urandom_range(0, 3);
            run_txn(ra, rb, d, h, ref_gcd(ra, rb), 1'b0,
                    (ra == 0 || rb == 0) ? 0 : 8 + d, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
